pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised fetch-stage program counter for the pipelined CPU; successor to the single-register PC.
- Holds the fetch PC and selects the next PC from: exception vector, exception return, back-end redirect, return-address-stack (RAS) prediction, or sequential increment.
- Contains an EPC register and a circular RAS of configurable depth.
- Sits between the hazard unit (stall) and instruction memory (fetch address).

Parameters:
- WIDTH, 32, PC/address width in bits (≥ 8).
- RESET_VEC, 32'h00003000, PC value after reset (truncated to WIDTH).
- EXC_VEC, 32'h00004180, exception entry address.
- INC, 4, sequential increment.
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥ 2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall_f  in  1  hazard-unit stall; freezes PC and RAS.
- redirect_en  in  1  back-end branch/jump resolution.
- redirect_pc  in  WIDTH  target for redirect_en.
- exc_en  in  1  take exception.
- eret_en  in  1  return from exception.
- ras_push  in  1  fetch decoded a call; push ras_push_data.
- ras_push_data  in  WIDTH  link address to push.
- ras_pop  in  1  fetch decoded a return; predict from RAS top.
- pc  out  WIDTH  current fetch address (registered).
- epc  out  WIDTH  saved exception PC (registered).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  out  1  ras_count == 0.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_underflow  out  1  registered one-cycle pulse: pop attempted while empty.
- misalign  out  1  combinational; pc[1:0] != 0.

Behaviour:
- Reset (reset = 0, asynchronous):
  - pc = RESET_VEC, epc = 0.
  - RAS pointer = 0, ras_count = 0, all entries = 0, ras_underflow = 0.
  - On reset release, pc = RESET_VEC for the first fetch.
- Next-PC priority, evaluated each rising edge (highest first):
  1. exc_en: pc <= EXC_VEC; epc <= pc (the current fetch PC).
  2. eret_en: pc <= epc.
  3. redirect_en: pc <= redirect_pc.
  4. stall_f: pc holds.
  5. ras_pop and RAS non-empty: pc <= RAS top.
  6. Otherwise: pc <= pc + INC, wrapping modulo 2^WIDTH.
- exc_en, eret_en and redirect_en override stall_f so back-end events are never lost. Only one of the three acts per edge, by the priority above.
- epc changes only on exc_en.
- RAS updates only when stall_f = 0 and none of exc_en, eret_en or redirect_en is active. In those cases push and pop are discarded and the RAS is unchanged.
- Push only:
  - Write at ptr; ptr <= ptr + 1 mod RAS_DEPTH.
  - ras_count saturates at RAS_DEPTH. A push while full overwrites the oldest entry (circular).
- Pop only, non-empty: ptr <= ptr − 1; ras_count − 1.
- Pop only, empty:
  - Falls through to sequential pc + INC.
  - RAS unchanged.
  - ras_underflow = 1 for exactly the next cycle.
- Push and pop together, non-empty:
  - pc <= old top.
  - Top entry replaced by ras_push_data.
  - ptr and ras_count unchanged.
- Push and pop together, empty: behaves as push only; pc <= pc + INC; no underflow pulse.
- ras_underflow is cleared every cycle in which its set condition is false.
- No alignment correction: redirect_pc and epc are loaded verbatim; misalign flags the result for the exception logic.
- Latency: every selection takes effect on the edge at which it is sampled; pc is valid one cycle after the control inputs.

Test Plan:
- Reset then release, no controls: pc = 3000, 3004, 3008; assert reset = 0 mid-cycle → pc = 3000 immediately, with no clock edge.
- stall_f = 1 for 3 cycles at pc = 3010 → pc stays 3010; add redirect_en = 1 with redirect_pc = 3100 while stalled → pc = 3100 on the next edge.
- At pc = 3020, assert exc_en and redirect_en together → pc = 4180, epc = 3020. Then eret_en → pc = 3020.
- Push 0x3104, 0x3204, 0x3304, 0x3404, 0x3504 (DEPTH 4) → ras_full = 1 after the 4th push, count stays 4. Then 4 pops → pc = 3504, 3404, 3304, 3204, ras_empty = 1.
- Pop while empty at pc = 3040 → pc = 3044, ras_underflow high for one cycle, count = 0.
- RAS holds [3104]: assert push 3204 and pop together → pc = 3104, count = 1, top = 3204. Then pop with stall_f = 1 → RAS unchanged.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-PC interface: control from hazard unit / back-end in, fetch address and RAS status out.
// Latency: pure wiring, no storage.
// Backpressure: none in the bundle itself; stall_f is carried as an ordinary control wire.
interface pc_unit_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             stall_f;
    logic             redirect_en;
    logic [WIDTH-1:0] redirect_pc;
    logic             exc_en;
    logic             eret_en;
    logic             ras_push;
    logic [WIDTH-1:0] ras_push_data;
    logic             ras_pop;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] epc;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_underflow;
    logic             misalign;

    // Drives the controls and observes the PC state.
    modport master (
        output stall_f, redirect_en, redirect_pc, exc_en, eret_en,
               ras_push, ras_push_data, ras_pop,
        input  pc, epc, ras_count, ras_empty, ras_full, ras_underflow, misalign
    );

    // The PC unit itself.
    modport slave (
        input  stall_f, redirect_en, redirect_pc, exc_en, eret_en,
               ras_push, ras_push_data, ras_pop,
        output pc, epc, ras_count, ras_empty, ras_full, ras_underflow, misalign
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage PC: picks exception / eret / redirect / hold / RAS-predict / sequential next PC; holds EPC and a circular RAS.
// Latency: one cycle, every selection lands on the edge at which it is sampled.
// Backpressure: stall_f freezes PC and RAS, but exception, eret and redirect still act so back-end events are never lost.
module pc_unit #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          INC       = 4,
    parameter int          RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
    localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             uf_q, uf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             ras_we;
    logic [PW-1:0]    ras_waddr;
    logic [WIDTH-1:0] ras_wdat;
    logic [PW-1:0]    ptr_m1;
    logic             ras_empty;
    logic             ras_full;

    // ptr points at the next free slot, so the top of stack is one below it.
    assign ptr_m1    = ptr_q - PW'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);

    // Next-PC selection and RAS bookkeeping; RAS only moves on an unstalled cycle with no back-end event.
    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        uf_d      = 1'b0;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        ras_wdat  = bus.ras_push_data;
        if (bus.exc_en) begin
            pc_d  = EXC_PC;
            epc_d = pc_q;
        end else if (bus.eret_en) begin
            pc_d = epc_q;
        end else if (bus.redirect_en) begin
            pc_d = bus.redirect_pc;
        end else if (bus.stall_f) begin
            pc_d = pc_q;
        end else if (bus.ras_pop && !ras_empty) begin
            pc_d = ras_q[ptr_m1];
            if (bus.ras_push) begin
                // Return immediately followed by a call: swap the top in place.
                ras_we    = 1'b1;
                ras_waddr = ptr_m1;
            end else begin
                ptr_d = ptr_m1;
                cnt_d = cnt_q - CW'(1);
            end
        end else begin
            pc_d = pc_q + INC_W;
            if (bus.ras_push) begin
                // When full the write lands on the oldest entry, giving circular overwrite.
                ras_we    = 1'b1;
                ras_waddr = ptr_q;
                ptr_d     = ptr_q + PW'(1);
                if (!ras_full) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (bus.ras_pop) begin
                uf_d = 1'b1;
            end
        end
    end

    // PC, EPC and RAS control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RST_PC;
            epc_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

    // RAS entry storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (ras_we) begin
            ras_q[ras_waddr] <= ras_wdat;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.epc           = epc_q;
    assign bus.ras_count     = cnt_q;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.ras_underflow = uf_q;
    assign bus.misalign      = (pc_q[1:0] != 2'b00);
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table walked edge by edge, plus async-reset sequences.
// Latency: every vector is checked 1 time unit after the edge that consumes it.
// Backpressure: stall_f exercised alone and combined with back-end events.
module tb_pc_unit;
    logic clk;
    logic reset;

    pc_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

    pc_unit #(
        .WIDTH    (32),
        .RESET_VEC(32'h0000_3000),
        .EXC_VEC  (32'h0000_4180),
        .INC      (4),
        .RAS_DEPTH(4)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exc;
        logic        eret;
        logic        push;
        logic [31:0] pdat;
        logic        pop;
        logic [31:0] exp_pc;
        logic [31:0] exp_epc;
        int          exp_cnt;
        logic        exp_uf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic stall, input logic redir, input logic [31:0] rpc,
                       input logic exc, input logic eret, input logic push,
                       input logic [31:0] pdat, input logic pop,
                       input logic [31:0] exp_pc, input logic [31:0] exp_epc,
                       input int exp_cnt, input logic exp_uf);
        vec_t v;
        v.stall = stall; v.redir = redir; v.rpc = rpc; v.exc = exc; v.eret = eret;
        v.push = push; v.pdat = pdat; v.pop = pop;
        v.exp_pc = exp_pc; v.exp_epc = exp_epc; v.exp_cnt = exp_cnt; v.exp_uf = exp_uf;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.stall_f       = v.stall;
        bus.redirect_en   = v.redir;
        bus.redirect_pc   = v.rpc;
        bus.exc_en        = v.exc;
        bus.eret_en       = v.eret;
        bus.ras_push      = v.push;
        bus.ras_push_data = v.pdat;
        bus.ras_pop       = v.pop;
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = '{default: '0};
        drive(v);
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                               input int cnt, input logic uf);
        check({tag, " pc"}, bus.pc, pc);
        check({tag, " epc"}, bus.epc, epc);
        check({tag, " count"}, 32'(bus.ras_count), 32'(cnt));
        check({tag, " empty"}, 32'(bus.ras_empty), 32'(cnt == 0));
        check({tag, " full"}, 32'(bus.ras_full), 32'(cnt == 4));
        check({tag, " underflow"}, 32'(bus.ras_underflow), 32'(uf));
        check({tag, " misalign"}, 32'(bus.misalign), 32'(pc[1:0] != 2'b00));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //  stall redir rpc           exc eret push pdat         pop  exp_pc        exp_epc     cnt uf
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h3004,     32'h0,    0, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h3008,     32'h0,    0, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h300C,     32'h0,    0, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h3010,     32'h0,    0, 0);
        add(1, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h3010,     32'h0,    0, 0);
        add(1, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h3010,     32'h0,    0, 0);
        add(1, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h3010,     32'h0,    0, 0);
        add(1, 1, 32'h3100,       0, 0, 0, 32'h0,    0, 32'h3100,     32'h0,    0, 0);
        add(0, 1, 32'h301C,       0, 0, 0, 32'h0,    0, 32'h301C,     32'h0,    0, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h3020,     32'h0,    0, 0);
        add(0, 1, 32'h3500,       1, 0, 0, 32'h0,    0, 32'h4180,     32'h3020, 0, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h4184,     32'h3020, 0, 0);
        add(0, 1, 32'h3600,       0, 1, 0, 32'h0,    0, 32'h3020,     32'h3020, 0, 0);
        add(0, 0, 32'h0,          0, 0, 1, 32'h3104, 0, 32'h3024,     32'h3020, 1, 0);
        add(0, 0, 32'h0,          0, 0, 1, 32'h3204, 0, 32'h3028,     32'h3020, 2, 0);
        add(0, 0, 32'h0,          0, 0, 1, 32'h3304, 0, 32'h302C,     32'h3020, 3, 0);
        add(0, 0, 32'h0,          0, 0, 1, 32'h3404, 0, 32'h3030,     32'h3020, 4, 0);
        add(0, 0, 32'h0,          0, 0, 1, 32'h3504, 0, 32'h3034,     32'h3020, 4, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    1, 32'h3504,     32'h3020, 3, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    1, 32'h3404,     32'h3020, 2, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    1, 32'h3304,     32'h3020, 1, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    1, 32'h3204,     32'h3020, 0, 0);
        add(0, 1, 32'h3040,       0, 0, 0, 32'h0,    0, 32'h3040,     32'h3020, 0, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    1, 32'h3044,     32'h3020, 0, 1);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h3048,     32'h3020, 0, 0);
        add(0, 0, 32'h0,          0, 0, 1, 32'h3104, 0, 32'h304C,     32'h3020, 1, 0);
        add(0, 0, 32'h0,          0, 0, 1, 32'h3204, 1, 32'h3104,     32'h3020, 1, 0);
        add(1, 0, 32'h0,          0, 0, 0, 32'h0,    1, 32'h3104,     32'h3020, 1, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    1, 32'h3204,     32'h3020, 0, 0);
        add(0, 0, 32'h0,          0, 0, 1, 32'h3600, 1, 32'h3208,     32'h3020, 1, 0);
        add(0, 1, 32'h3700,       0, 0, 1, 32'h3800, 0, 32'h3700,     32'h3020, 1, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    1, 32'h3600,     32'h3020, 0, 0);
        add(0, 1, 32'h3702,       0, 0, 0, 32'h0,    0, 32'h3702,     32'h3020, 0, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h3706,     32'h3020, 0, 0);
        add(1, 1, 32'h3900,       1, 1, 0, 32'h0,    0, 32'h4180,     32'h3706, 0, 0);
        add(1, 0, 32'h0,          0, 1, 0, 32'h0,    0, 32'h3706,     32'h3706, 0, 0);
        add(0, 1, 32'hFFFF_FFFC,  0, 0, 0, 32'h0,    0, 32'hFFFF_FFFC, 32'h3706, 0, 0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h0,        32'h3706, 0, 0);
        add(1, 0, 32'h0,          0, 0, 0, 32'h0,    1, 32'h0,        32'h3706, 0, 0);

        // Power-on reset and first fetch address.
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 32'h3000, 32'h0, 0, 1'b0);
        reset = 1'b1;
        #1;
        check("first fetch pc", bus.pc, 32'h3000);

        // Walk the vector table, one edge per record.
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_epc,
                        vecs[i].exp_cnt, vecs[i].exp_uf);
        end

        // Underflow pulse, then asynchronous reset mid-cycle clears everything without an edge.
        idle_inputs();
        bus.ras_pop = 1'b1;
        @(posedge clk);
        #1;
        check("pre-reset underflow", 32'(bus.ras_underflow), 32'd1);
        bus.ras_pop = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_state("async reset", 32'h3000, 32'h0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release pc", bus.pc, 32'h3000);
        @(posedge clk);
        #1;
        check("release +1 pc", bus.pc, 32'h3004);

        // RAS cleared by reset: a pop right after release must underflow.
        bus.ras_pop = 1'b1;
        @(posedge clk);
        #1;
        check_state("post-reset pop", 32'h3008, 32'h0, 0, 1'b1);
        bus.ras_pop = 1'b0;
        @(posedge clk);
        #1;
        check_state("underflow clears", 32'h300C, 32'h0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
